pulse_shaping_fir: RTL
======================

# pulse_shaping_fir

Transmit pulse-shaping filter placed directly downstream of the ×4 up-sampler. It consumes one 2-bit signed up-sampled sample per 4× clock, convolves the stream with a fixed 16-tap symmetric root-raised-cosine coefficient set, and emits a full-precision signed result with a valid flag. Each of the I and Q rails uses one instance.

## Interface
- TAPS, 16, number of filter taps (even, symmetric set)
- DIN_W, 2, input sample width, two's complement
- COEF_W, 8, coefficient width, two's complement
- OUT_W, 14, output width = DIN_W + COEF_W + log2(TAPS); lossless
- clk  in  1  4× sample clock (same clock as the up-sampler)
- reset  in  1  asynchronous, active-low; clears all state
- en  in  1  sample-valid: din is accepted on rising clk when en=1
- din  in  DIN_W  up-sampled sample, signed (01=+1, 00=0, 11=−1, 10=−2)
- dout  out  OUT_W  filtered sample, signed
- dout_valid  out  1  dout carries a new result this cycle

## Operation
- Coefficients c[0..15] = −3, −5, 0, 12, 28, 48, 66, 76, 76, 66, 48, 28, 12, 0, −5, −3.
- dout(n) = Σ c[k]·x(n−k), k=0..15, where x(n) is the n-th accepted sample. x(−m) = 0 after reset.
- Delay line: tap[0] ← din and tap[k] ← tap[k−1] on each accepted sample. With en=0 the line holds.
- Three-stage pipeline:
  - S1 is the delay line.
  - S2 registers the 16 products tap[k]·c[k] (sign-extended, DIN_W+COEF_W bits each).
  - S3 sums the products into dout.
- A valid bit travels with the data: v1 ← en, v2 ← v1, dout_valid ← v2.
- S2 and S3 update only when their incoming valid bit is 1. Otherwise they hold, so dout holds its last value while dout_valid=0.
- Arithmetic is full precision, with no rounding or saturation. The worst-case magnitude is 2·476 = 952, which fits OUT_W.
- The −2 code is legal and is treated arithmetically.

## Timing
- Reset (reset=0) is asynchronous. All taps, products, valid bits, dout and dout_valid go to 0 immediately.
- Reset release is synchronous to clk. The first acceptance is the first rising edge with reset=1 and en=1.
- Latency: a sample accepted at edge E0 contributes to the dout that is registered at edge E0+2. dout_valid is 1 in the cycle after E0+2.
- Continuous en=1 gives one result per clock.
- en gaps: each gap cycle produces exactly one dout_valid=0 cycle, delayed by 2. No samples are lost or duplicated.
- Reset asserted mid-stream discards all history. After release, output restarts as if the filter had been freshly reset, with zero history.
- en is ignored while reset=0.

## Structure
- Package ps_fir_pkg holds:
  - TAPS, DIN_W, COEF_W, OUT_W
  - the coefficient array constant (signed COEF_W × TAPS)
  - the OUT_W derivation function
- Sub-module ps_delay_line: TAPS×DIN_W shift register with enable and async active-low clear. It exposes all taps flat.
- Products and the final sum live in pulse_shaping_fir. A symmetric pre-add (tap[k]+tap[15−k]) is permitted internally, provided latency and outputs are unchanged.

## Test plan
- Impulse: reset, then en=1 and din = +1 followed by 20 zeros.
  - The 16 valid outputs starting 3 edges after capture are −3, −5, 0, 12, 28, 48, 66, 76, 76, 66, 48, 28, 12, 0, −5, −3.
  - The output is 0 after that.
- Step: reset, then din=+1 continuously.
  - The 16th valid output onward equals 444 (Σc).
  - Negative step din=−1 settles at −444. din=−2 settles at −888.
- Up-sampled symbol stream: din sequence +1, 0, 0, 0, −1, 0, 0, 0.
  - Output equals the golden convolution computed by the bench model, sample by sample.
- en gaps: impulse stream with en toggled 1,0,0,1,…
  - The dout_valid=1 sequence is identical to the continuous-en case.
  - dout is held during invalid cycles.
- Reset mid-operation: during a +1 step, pull reset low for half a cycle, asynchronously to clk.
  - dout=0 and dout_valid=0 immediately.
  - After release, the output ramps again from −3 as in the step test.
- Extreme: din pattern +1 where c>0 and −2 where c<0, aligned to the taps.
  - Output = 492.
  - No overflow is visible in a bench sign check.

Source files
------------

// File: rtl/ps_fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps_fir_pkg                                                           |
// | Shared sizes and the RRC coefficient set for the pulse-shaping FIR.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps_fir_pkg;

   localparam int TAPS   = 16;
   localparam int DIN_W  = 2;
   localparam int COEF_W = 8;

   // Lossless accumulator width for TAPS products of DIN_W x COEF_W operands
   function automatic int out_width(input int din_w, input int coef_w, input int taps);
      return din_w + coef_w + $clog2(taps);
   endfunction

   localparam int OUT_W  = out_width(DIN_W, COEF_W, TAPS);
   localparam int PROD_W = DIN_W + COEF_W;

   localparam logic signed [COEF_W-1:0] COEFS [TAPS] = '{
      -8'sd3,  -8'sd5,  8'sd0,   8'sd12,  8'sd28,  8'sd48,  8'sd66,  8'sd76,
       8'sd76,  8'sd66, 8'sd48,  8'sd28,  8'sd12,  8'sd0,  -8'sd5,  -8'sd3
   };

endpackage
`default_nettype wire

// File: rtl/ps_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps_delay_line                                                        |
// | TAPS x DIN_W sample shift register; tap[0] occupies the low bits.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps_delay_line
   import ps_fir_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [DIN_W-1:0]        din,
   output logic [TAPS*DIN_W-1:0]   taps
);

   logic [TAPS*DIN_W-1:0] r_taps;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_taps <= '0;
      end else if (en) begin
         r_taps <= {r_taps[(TAPS-1)*DIN_W-1:0], din};
      end
   end

   assign taps = r_taps;

endmodule
`default_nettype wire

// File: rtl/pulse_shaping_fir.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_shaping_fir                                                    |
// | 16-tap RRC transmit filter: delay line, product register, sum reg.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pulse_shaping_fir
   import ps_fir_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [DIN_W-1:0]    din,
   output logic [OUT_W-1:0]    dout,
   output logic                dout_valid
);

   logic [TAPS*DIN_W-1:0]      w_taps;
   logic signed [PROD_W-1:0]   w_prod [TAPS];
   logic signed [PROD_W-1:0]   r_prod [TAPS];
   logic [OUT_W-1:0]           w_sum;
   logic                       r_v1;
   logic                       r_v2;
   logic [OUT_W-1:0]           r_dout;
   logic                       r_dout_valid;

   ps_delay_line u_delay_line (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .din   (din),
      .taps  (w_taps)
   );

   // Both operands widened to PROD_W so the truncated product is exact
   generate
      for (genvar k = 0; k < TAPS; k++) begin : g_prod
         logic [DIN_W-1:0]   w_tap;
         logic [PROD_W-1:0]  w_tap_ext;
         logic [PROD_W-1:0]  w_coef_ext;
         assign w_tap      = w_taps[k*DIN_W +: DIN_W];
         assign w_tap_ext  = {{COEF_W{w_tap[DIN_W-1]}}, w_tap};
         assign w_coef_ext = {{DIN_W{COEFS[k][COEF_W-1]}}, COEFS[k]};
         assign w_prod[k]  = w_tap_ext * w_coef_ext;
      end
   endgenerate

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_sum = w_sum + {{(OUT_W-PROD_W){r_prod[k][PROD_W-1]}}, r_prod[k]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
         for (int k = 0; k < TAPS; k++) begin
            r_prod[k] <= '0;
         end
      end else begin
         r_v1         <= en;
         r_v2         <= r_v1;
         r_dout_valid <= r_v2;
         if (r_v1) begin
            for (int k = 0; k < TAPS; k++) begin
               r_prod[k] <= w_prod[k];
            end
         end
         if (r_v2) begin
            r_dout <= w_sum;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire
